// File: rtl/sbox_layer_serial.sv
// Serial PRESENT S-box layer: substitutes NIB_PER_CYC nibbles per clock and hands the state to PLayer.
// Optional macro SBOX_INV_EN adds an 'inv' input that selects the inverse S-box for the decrypt path.
//
// state | meaning
// IDLE  | waiting for a new state, in_ready high
// RUN   | substituting one slice of nibbles per cycle
// DONE  | substituted state presented, waiting for out_ready
module sbox_layer_serial #(
  parameter int SIZE        = 64,
  parameter int NIB_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
`ifdef SBOX_INV_EN
  input  logic            inv,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] state_out,
  output logic            busy
);

  localparam int NIB  = SIZE / 4;
  localparam int NCYC = NIB / NIB_PER_CYC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int SW   = 4 * NIB_PER_CYC;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] data_q;
  logic [SW-1:0]   cur;
  logic [SW-1:0]   sub;
  logic            accept;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    case (x)
      4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;  4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;  4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;  4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;  4'hE: sbox_fwd = 4'h1;  default: sbox_fwd = 4'h2;
    endcase
  endfunction

`ifdef SBOX_INV_EN
  logic inv_q;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset)       inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`endif

  assign accept = (fsm_q == IDLE) && in_valid;

  // One slice of nibbles goes through the S-boxes per cycle; cnt picks the slice.
  always_comb begin
    cur = '0;
    for (int c = 0; c < NCYC; c++)
      if (cnt_q == CW'(c)) cur = data_q[c*SW +: SW];
  end

  for (genvar j = 0; j < NIB_PER_CYC; j++) begin : g_sbox
`ifdef SBOX_INV_EN
    assign sub[j*4 +: 4] = inv_q ? sbox_inv(cur[j*4 +: 4]) : sbox_fwd(cur[j*4 +: 4]);
`else
    assign sub[j*4 +: 4] = sbox_fwd(cur[j*4 +: 4]);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        data_q <= state_in;
        cnt_q  <= '0;
      end else if (fsm_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
        for (int c = 0; c < NCYC; c++)
          if (cnt_q == CW'(c)) data_q[c*SW +: SW] <= sub;
      end
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == IDLE);
    busy      = (fsm_q == RUN);
    out_valid = (fsm_q == DONE);
  end

  assign state_out = data_q;

endmodule
